// File: rtl/instr_issue_if.sv
// Bus bundle for instr_issue: instruction intake, processor pins and result return.
// Handshakes: a transfer happens on a posedge where valid and ready are both 1; valid never waits on ready.
interface instr_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] in_word;
    logic [2:0]  instr;
    logic [4:0]  read1;
    logic [4:0]  read2;
    logic [4:0]  write;
    logic [15:0] writed;
    logic        done;
    logic [15:0] readd1;
    logic [15:0] readd2;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_op;
    logic [15:0] res_d1;
    logic [15:0] res_d2;
    logic        res_err;
    logic        busy;

    modport slave (
        input  in_valid, in_word, done, readd1, readd2, res_ready,
        output in_ready, instr, read1, read2, write, writed,
        output res_valid, res_op, res_d1, res_d2, res_err, busy
    );

    modport master (
        output in_valid, in_word, done, readd1, readd2, res_ready,
        input  in_ready, instr, read1, read2, write, writed,
        input  res_valid, res_op, res_d1, res_d2, res_err, busy
    );
endinterface

// File: rtl/instr_issue.sv
// Issue stage: instruction FIFO feeding a 4-state issue/wait/retire FSM toward the processor.
// Define INSTR_ISSUE_PERF_EN to add the perf_retired / perf_stall counters.
module instr_issue #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_issue_if.slave  bus,
    output logic [1:0]    dbg_state_o
`ifdef INSTR_ISSUE_PERF_EN
    ,
    output logic [15:0]   perf_retired,
    output logic [15:0]   perf_stall
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETIRE = 2'd3
    } state_e;

    state_e        state_q;
    logic [2:0]    instr_q;
    logic [4:0]    read1_q, read2_q, write_q;
    logic [15:0]   writed_q;
    logic          res_valid_q, res_err_q;
    logic [2:0]    res_op_q;
    logic [15:0]   res_d1_q, res_d2_q;
    logic [CW-1:0] wait_cnt_q;

    logic [33:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    logic [33:0]   head;

    assign bus.in_ready = (count_q < CNT_FULL);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (pop && !push) count_d = count_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            instr_q     <= 3'd1;
            read1_q     <= '0;
            read2_q     <= '0;
            write_q     <= '0;
            writed_q    <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_op_q    <= '0;
            res_d1_q    <= '0;
            res_d2_q    <= '0;
            wait_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        instr_q  <= head[33:31];
                        read1_q  <= head[30:26];
                        read2_q  <= head[25:21];
                        write_q  <= head[20:16];
                        writed_q <= head[15:0];
                        state_q  <= S_ISSUE;
                    end else begin
                        instr_q  <= 3'd1;
                        read1_q  <= '0;
                        read2_q  <= '0;
                        write_q  <= '0;
                        writed_q <= '0;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the last allowed cycle still wins over the timeout.
                    if (bus.done || (wait_cnt_q == WAIT_LAST)) begin
                        res_valid_q <= 1'b1;
                        res_op_q    <= instr_q;
                        res_err_q   <= !bus.done;
                        res_d1_q    <= bus.done ? bus.readd1 : 16'd0;
                        res_d2_q    <= bus.done ? bus.readd2 : 16'd0;
                        instr_q     <= 3'd1;
                        read1_q     <= '0;
                        read2_q     <= '0;
                        write_q     <= '0;
                        writed_q    <= '0;
                        state_q     <= S_RETIRE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                S_RETIRE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.instr     = instr_q;
    assign bus.read1     = read1_q;
    assign bus.read2     = read2_q;
    assign bus.write     = write_q;
    assign bus.writed    = writed_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_op    = res_op_q;
    assign bus.res_d1    = res_d1_q;
    assign bus.res_d2    = res_d2_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = (state_q != S_IDLE) || (count_q != '0);
    assign dbg_state_o   = state_q;

`ifdef INSTR_ISSUE_PERF_EN
    logic [15:0] perf_retired_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if ((state_q == S_RETIRE) && bus.res_ready)
                perf_retired_q <= perf_retired_q + 16'd1;
            if ((state_q == S_WAIT) && (perf_stall_q != 16'hFFFF))
                perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue with a small processor model answering on the pins.
module tb_instr_issue;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  instr_issue_if bus();
`ifdef INSTR_ISSUE_PERF_EN
  logic [15:0] perf_retired, perf_stall;
`endif

  instr_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state_o(dbg_state)
`ifdef INSTR_ISSUE_PERF_EN
    ,
    .perf_retired(perf_retired),
    .perf_stall(perf_stall)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [35:0] exp_q[$];
  logic tie_done = 1'b0;
  int wait_run = 0;
  int last_wait = 0;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [4:0] w, input logic [15:0] d);
    return {op, r1, r2, w, d};
  endfunction

  function automatic logic [35:0] res(input logic [2:0] op, input logic [15:0] d1, input logic [15:0] d2,
                                      input logic err);
    return {op, d1, d2, err};
  endfunction

  // processor model: samples pins in ISSUE, answers after 2 (ops 0-4) or 18 (ops 5-7) cycles
  initial begin
    logic [15:0] regs [32];
    logic pend;
    int lat;
    logic [15:0] a1, a2;
    for (int i = 0; i < 32; i++) regs[i] = 16'd0;
    pend = 1'b0; lat = 0; a1 = 16'd0; a2 = 16'd0;
    bus.done = 1'b0; bus.readd1 = 16'd0; bus.readd2 = 16'd0;
    forever begin
      @(negedge clk);
      bus.done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        if (lat <= 1) begin
          bus.done = !tie_done;
          bus.readd1 = a1;
          bus.readd2 = a2;
          pend = 1'b0;
        end else begin
          lat--;
        end
      end else if (dbg_state == ST_ISSUE) begin
        a1 = 16'd0; a2 = 16'd0;
        case (bus.instr)
          3'd0: regs[bus.write] = bus.writed;
          3'd1: begin a1 = regs[bus.read1]; a2 = regs[bus.read2]; end
          3'd2: begin a1 = bus.writed; a2 = ~bus.writed; end
          3'd5: a1 = regs[bus.read1] + regs[bus.read2];
          default: ;
        endcase
        lat = (bus.instr >= 3'd5) ? 18 : 2;
        pend = 1'b1;
      end
    end
  end

  // length of the most recent WAIT stretch
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) wait_run = 0;
      else if (dbg_state == ST_WAIT) wait_run++;
      else if (wait_run != 0) begin
        last_wait = wait_run;
        wait_run = 0;
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic push_word(input logic [33:0] w, output logic acc);
    bus.in_valid = 1'b1;
    bus.in_word = w;
    acc = bus.in_ready;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int n;
    logic [35:0] e;
    n = 0;
    while (!bus.res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 36'(bus.res_valid), 36'(1));
    if (!bus.res_valid) return;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 36'h0;
    check_eq({tag, "_op"}, 36'(bus.res_op), 36'(e[35:33]));
    check_eq({tag, "_d1"}, 36'(bus.res_d1), 36'(e[32:17]));
    check_eq({tag, "_d2"}, 36'(bus.res_d2), 36'(e[16:1]));
    check_eq({tag, "_err"}, 36'(bus.res_err), 36'(e[0]));
    check_eq({tag, "_benign"}, 36'({bus.instr, bus.read1}), 36'({3'd1, 5'd0}));
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_eq({tag, "_drop"}, 36'(bus.res_valid), 36'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int n;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word = 34'd0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check_eq("rst_instr", 36'(bus.instr), 36'(1));
    check_eq("rst_fields", 36'({bus.read1, bus.read2, bus.write, bus.writed}), 36'(0));
    check_eq("rst_res", 36'({bus.res_valid, bus.res_op, bus.res_d1, bus.res_err}), 36'(0));
    check_eq("rst_ready", 36'(bus.in_ready), 36'(1));
    check_eq("rst_busy", 36'(bus.busy), 36'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // write then read back, with issue latency
    exp_q.push_back(res(3'd0, 16'h0, 16'h0, 1'b0));
    push_word(mk(3'd0, 5'd0, 5'd0, 5'd3, 16'hBEEF), acc);
    check_eq("lat_still_benign", 36'(bus.instr), 36'(1));
    check_eq("lat_busy", 36'(bus.busy), 36'(1));
    @(negedge clk);
    check_eq("lat_instr", 36'(bus.instr), 36'(0));
    check_eq("lat_write", 36'(bus.write), 36'(3));
    check_eq("lat_writed", 36'(bus.writed), 36'(16'hBEEF));
    exp_q.push_back(res(3'd1, 16'hBEEF, 16'h0, 1'b0));
    push_word(mk(3'd1, 5'd3, 5'd0, 5'd0, 16'h0), acc);
    get_result("wr_beef");
    get_result("rd_beef");

    // long op: 10 + 5
    exp_q.push_back(res(3'd0, 16'h0, 16'h0, 1'b0));
    exp_q.push_back(res(3'd0, 16'h0, 16'h0, 1'b0));
    exp_q.push_back(res(3'd5, 16'd15, 16'h0, 1'b0));
    push_word(mk(3'd0, 5'd0, 5'd0, 5'd3, 16'd10), acc);
    push_word(mk(3'd0, 5'd0, 5'd0, 5'd4, 16'd5), acc);
    push_word(mk(3'd5, 5'd3, 5'd4, 5'd0, 16'h0), acc);
    get_result("wr3");
    get_result("wr4");
    n = 0;
    while (dbg_state != ST_WAIT && n < 100) begin @(negedge clk); n++; end
    check_eq("op5_wait_instr", 36'({bus.instr, bus.read1, bus.read2}), 36'({3'd5, 5'd3, 5'd4}));
    get_result("add");
    check_eq("op5_wait_len", 36'(last_wait >= 18), 36'(1));

    // fill FIFO with consumer stalled
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH + 1)
        exp_q.push_back(res(3'd2, 16'h1000 + 16'(i), ~(16'h1000 + 16'(i)), 1'b0));
      push_word(mk(3'd2, 5'd0, 5'd0, 5'd0, 16'h1000 + 16'(i)), acc);
      check_eq($sformatf("fill_acc%0d", i), 36'(acc), 36'(i < DEPTH + 1));
    end
    check_eq("full_ready", 36'(bus.in_ready), 36'(0));
    for (int i = 0; i < DEPTH + 1; i++) get_result($sformatf("fifo%0d", i));
    check_eq("drain_busy", 36'(bus.busy), 36'(0));

    // timeout
    tie_done = 1'b1;
    exp_q.push_back(res(3'd3, 16'h0, 16'h0, 1'b1));
    push_word(mk(3'd3, 5'd1, 5'd2, 5'd0, 16'h0), acc);
    get_result("tmo");
    check_eq("tmo_len", 36'(last_wait), 36'(TIMEOUT));
    tie_done = 1'b0;

    // reset mid-WAIT of op5 with more words queued
    push_word(mk(3'd5, 5'd3, 5'd4, 5'd0, 16'h0), acc);
    push_word(mk(3'd1, 5'd3, 5'd0, 5'd0, 16'h0), acc);
    push_word(mk(3'd1, 5'd4, 5'd0, 5'd0, 16'h0), acc);
    n = 0;
    while (dbg_state != ST_WAIT && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_instr", 36'({bus.instr, bus.read1}), 36'({3'd1, 5'd0}));
    check_eq("mrst_res_valid", 36'(bus.res_valid), 36'(0));
    check_eq("mrst_ready", 36'(bus.in_ready), 36'(1));
    check_eq("mrst_busy", 36'(bus.busy), 36'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_idle", 36'({bus.instr, bus.busy, bus.res_valid}), 36'({3'd1, 1'b0, 1'b0}));

    // three short reads after reset
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(res(3'd1, 16'd10, 16'd5, 1'b0));
      push_word(mk(3'd1, 5'd3, 5'd4, 5'd0, 16'h0), acc);
      get_result($sformatf("post%0d", i));
    end
`ifdef INSTR_ISSUE_PERF_EN
    check_eq("perf_retired", 36'(perf_retired), 36'(3));
    check_eq("perf_stall", 36'(perf_stall), 36'(6));
`endif
    check_eq("sb_empty", 36'(exp_q.size()), 36'(0));

    // report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
